// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Valid/ready issue controller for the combinational ALU; decodes
//           ALUOp/funct, drives the ALU and returns captured result/flags.
//           Optional ALU_ISSUE_OVF_TRAP_EN adds the ovf_trap output.
// Revision: 1.0
// ============================================================================
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              alu_rst_n,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_cout,
  output logic              rsp_overflow,
  output logic              rsp_err
`ifdef ALU_ISSUE_OVF_TRAP_EN
  ,
  output logic              ovf_trap
`endif
);

  localparam logic [CTRL_W-1:0] c_ctrl_and = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] c_ctrl_or  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] c_ctrl_add = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] c_ctrl_sub = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] c_ctrl_slt = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] c_ctrl_nor = CTRL_W'(4'b1100);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CTRL_W-1:0]  w_dec_ctrl;
  logic               w_dec_legal;
  logic               w_accept;
  logic               w_rsp_hs;

  assign alu_rst_n = ~rst;
  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

  always_comb begin
    w_dec_ctrl  = c_ctrl_and;
    w_dec_legal = 1'b1;
    case (req_aluop)
      2'b00: w_dec_ctrl = c_ctrl_add;
      2'b01: w_dec_ctrl = c_ctrl_sub;
      2'b11: w_dec_ctrl = c_ctrl_or;
      default: begin
        case (req_funct)
          6'h24:   w_dec_ctrl = c_ctrl_and;
          6'h25:   w_dec_ctrl = c_ctrl_or;
          6'h20:   w_dec_ctrl = c_ctrl_add;
          6'h22:   w_dec_ctrl = c_ctrl_sub;
          6'h2A:   w_dec_ctrl = c_ctrl_slt;
          6'h27:   w_dec_ctrl = c_ctrl_nor;
          default: w_dec_legal = 1'b0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Illegal ops skip EXEC: there is nothing for the ALU to compute.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_dec_legal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_ctrl <= '0;
    end else if (w_accept && w_dec_legal) begin
      alu_src1 <= req_src1;
      alu_src2 <= req_src2;
      alu_ctrl <= w_dec_ctrl;
    end
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic w_trap;
  assign w_trap = ((alu_ctrl == c_ctrl_add) || (alu_ctrl == c_ctrl_sub)) && alu_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_trap <= 1'b0;
    end else if (r_state == S_EXEC) begin
      ovf_trap <= w_trap;
    end else if (w_rsp_hs) begin
      ovf_trap <= 1'b0;
    end
  end
`else
  logic w_trap;
  assign w_trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (w_accept && !w_dec_legal) begin
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b1;
    end else if (r_state == S_EXEC) begin
      rsp_result   <= w_trap ? '0 : alu_result;
      rsp_zero     <= alu_zero;
      rsp_cout     <= alu_cout;
      rsp_overflow <= alu_overflow;
      rsp_err      <= 1'b0;
    end
  end

endmodule
`default_nettype wire
